// File: rtl/dual_issue_queue_pkg.sv
// Shared constants for the dual-issue instruction queue: MIPS field positions,
// opcodes and default widths.
package dual_issue_queue_pkg;

    localparam int unsigned IWIDTH   = 32;
    localparam int unsigned PC_WIDTH = 32;
    localparam int unsigned AWIDTH   = 5;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] J     = 6'h02;
    localparam logic [5:0] JAL   = 6'h03;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] SW    = 6'h2B;

    localparam logic [5:0]        FUNCT_JR = 6'h08;
    localparam logic [AWIDTH-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/issue_pair_check.sv
// Pair-hazard check for two adjacent in-order instructions: decodes the older
// one's destination/control class and flags when the pair must be split.
module issue_pair_check #(
    parameter int unsigned IWIDTH = 32
) (
    input  logic [IWIDTH-1:0]                      instr_0,
    input  logic [IWIDTH-1:0]                      instr_1,
    output logic [dual_issue_queue_pkg::AWIDTH-1:0] dest,
    output logic                                   wr,
    output logic                                   ctrl,
    output logic                                   split
);
    import dual_issue_queue_pkg::*;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [AWIDTH-1:0] rt_0;
    logic [AWIDTH-1:0] rd_0;
    logic [AWIDTH-1:0] rs_1;
    logic [AWIDTH-1:0] rt_1;
    logic              unused_bits;

    assign opcode = instr_0[OPCODE_MSB:OPCODE_LSB];
    assign funct  = instr_0[FUNCT_MSB:FUNCT_LSB];
    assign rt_0   = instr_0[RT_MSB:RT_LSB];
    assign rd_0   = instr_0[RD_MSB:RD_LSB];
    assign rs_1   = instr_1[RS_MSB:RS_LSB];
    assign rt_1   = instr_1[RT_MSB:RT_LSB];

    assign unused_bits = ^{instr_0[RS_MSB:RS_LSB], instr_0[10:6],
                           instr_1[OPCODE_MSB:OPCODE_LSB], instr_1[RD_MSB:0]};

    always_comb begin
        dest = '0;
        ctrl = 1'b0;
        case (opcode)
            RTYPE: begin
                if (funct == FUNCT_JR) begin
                    ctrl = 1'b1;
                end else begin
                    dest = rd_0;
                end
            end
            JAL: begin
                dest = REG_RA;
                ctrl = 1'b1;
            end
            J, BEQ, BNE: ctrl = 1'b1;
            SW:          dest = '0;
            default:     dest = rt_0;
        endcase
        // r0 is hardwired, so a write to it never creates a dependency
        wr    = (dest != '0);
        split = ctrl || (wr && ((dest == rs_1) || (dest == rt_1)));
    end

endmodule

// File: rtl/dual_issue_queue.sv
// In-order circular instruction buffer: up to two enqueues and two issues per
// cycle, splitting the head pair on RAW or control hazards.
module dual_issue_queue #(
    parameter int unsigned IWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                     iq_clk,
    input  logic                     iq_rst,
    input  logic                     iq_i_flush,
    input  logic                     iq_i_valid_0,
    input  logic                     iq_i_valid_1,
    input  logic [IWIDTH-1:0]        iq_i_instr_0,
    input  logic [IWIDTH-1:0]        iq_i_instr_1,
    input  logic [PC_WIDTH-1:0]      iq_i_pc_0,
    input  logic [PC_WIDTH-1:0]      iq_i_pc_1,
    output logic                     iq_o_ready,
    input  logic                     iq_i_issue_ready,
    output logic                     iq_o_issue_valid_0,
    output logic                     iq_o_issue_valid_1,
    output logic [IWIDTH-1:0]        iq_o_instr_0,
    output logic [IWIDTH-1:0]        iq_o_instr_1,
    output logic [PC_WIDTH-1:0]      iq_o_pc_0,
    output logic [PC_WIDTH-1:0]      iq_o_pc_1,
    output logic                     iq_o_split,
    output logic [$clog2(DEPTH):0]   iq_o_count
);
    import dual_issue_queue_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [IWIDTH-1:0]   instr_q [DEPTH];
    logic [PC_WIDTH-1:0] pc_q    [DEPTH];

    logic [PW-1:0] head_q, head_d, head_p1;
    logic [PW-1:0] tail_q, tail_d, tail_p1;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]        enq_n;
    logic [1:0]        deq_n;
    logic              do_enq;
    logic              lane0;
    logic              lane1;
    logic              pair_present;
    logic              pair_split;
    logic [AWIDTH-1:0] head_dest;
    logic              head_wr;
    logic              head_ctrl;
    logic              unused_pair;

    // Power-of-two depth makes the natural pointer overflow the wrap
    assign head_p1 = head_q + PW'(1);
    assign tail_p1 = tail_q + PW'(1);

    issue_pair_check #(
        .IWIDTH (IWIDTH)
    ) u_pair_check (
        .instr_0 (instr_q[head_q]),
        .instr_1 (instr_q[head_p1]),
        .dest    (head_dest),
        .wr      (head_wr),
        .ctrl    (head_ctrl),
        .split   (pair_split)
    );

    assign unused_pair = ^{head_dest, head_wr, head_ctrl};

    assign iq_o_ready   = (CW'(DEPTH) - count_q) >= CW'(2);
    assign pair_present = count_q >= CW'(2);
    assign lane0        = count_q != '0;
    assign lane1        = pair_present && !pair_split;

    assign iq_o_issue_valid_0 = lane0;
    assign iq_o_issue_valid_1 = lane1;
    assign iq_o_split         = pair_present && pair_split;
    assign iq_o_instr_0       = lane0 ? instr_q[head_q]  : '0;
    assign iq_o_pc_0          = lane0 ? pc_q[head_q]     : '0;
    assign iq_o_instr_1       = lane1 ? instr_q[head_p1] : '0;
    assign iq_o_pc_1          = lane1 ? pc_q[head_p1]    : '0;
    assign iq_o_count         = count_q;

    // Slot 1 alone is not a legal request and is never accepted
    assign do_enq = iq_o_ready && iq_i_valid_0 && !iq_i_flush;
    assign enq_n  = do_enq ? (iq_i_valid_1 ? 2'd2 : 2'd1) : 2'd0;
    assign deq_n  = iq_i_issue_ready ? ({1'b0, lane0} + {1'b0, lane1}) : 2'd0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (iq_i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(deq_n);
            tail_d  = tail_q + PW'(enq_n);
            count_d = count_q + CW'(enq_n) - CW'(deq_n);
        end
    end

    always_ff @(posedge iq_clk or negedge iq_rst) begin
        if (!iq_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge iq_clk) begin
        if (do_enq) begin
            instr_q[tail_q] <= iq_i_instr_0;
            pc_q[tail_q]    <= iq_i_pc_0;
            if (iq_i_valid_1) begin
                instr_q[tail_p1] <= iq_i_instr_1;
                pc_q[tail_p1]    <= iq_i_pc_1;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Scoreboard bench for dual_issue_queue against a queue-based program-order model.
module tb_dual_issue_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          iq_clk = 1'b0;
    logic          iq_rst = 1'b0;
    logic          iq_i_flush = 1'b0;
    logic          iq_i_valid_0 = 1'b0;
    logic          iq_i_valid_1 = 1'b0;
    logic [31:0]   iq_i_instr_0 = '0;
    logic [31:0]   iq_i_instr_1 = '0;
    logic [31:0]   iq_i_pc_0 = '0;
    logic [31:0]   iq_i_pc_1 = '0;
    logic          iq_i_issue_ready = 1'b0;
    logic          iq_o_ready;
    logic          iq_o_issue_valid_0;
    logic          iq_o_issue_valid_1;
    logic [31:0]   iq_o_instr_0;
    logic [31:0]   iq_o_instr_1;
    logic [31:0]   iq_o_pc_0;
    logic [31:0]   iq_o_pc_1;
    logic          iq_o_split;
    logic [CW-1:0] iq_o_count;

    always #5 iq_clk = ~iq_clk;

    dual_issue_queue #(
        .IWIDTH   (32),
        .PC_WIDTH (32),
        .DEPTH    (DEPTH)
    ) dut (
        .iq_clk             (iq_clk),
        .iq_rst             (iq_rst),
        .iq_i_flush         (iq_i_flush),
        .iq_i_valid_0       (iq_i_valid_0),
        .iq_i_valid_1       (iq_i_valid_1),
        .iq_i_instr_0       (iq_i_instr_0),
        .iq_i_instr_1       (iq_i_instr_1),
        .iq_i_pc_0          (iq_i_pc_0),
        .iq_i_pc_1          (iq_i_pc_1),
        .iq_o_ready         (iq_o_ready),
        .iq_i_issue_ready   (iq_i_issue_ready),
        .iq_o_issue_valid_0 (iq_o_issue_valid_0),
        .iq_o_issue_valid_1 (iq_o_issue_valid_1),
        .iq_o_instr_0       (iq_o_instr_0),
        .iq_o_instr_1       (iq_o_instr_1),
        .iq_o_pc_0          (iq_o_pc_0),
        .iq_o_pc_1          (iq_o_pc_1),
        .iq_o_split         (iq_o_split),
        .iq_o_count         (iq_o_count)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct packed {
        logic          v0;
        logic          v1;
        logic          split;
        logic          ready;
        logic [CW-1:0] count;
        logic [31:0]   i0;
        logic [31:0]   p0;
        logic [31:0]   i1;
        logic [31:0]   p1;
    } exp_t;

    ent_t        mq[$];
    exp_t        eq[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] next_pc = '0;
    int          kk = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [4:0] dest_of(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        if (op == 6'h00) return (ins[5:0] == 6'h08) ? 5'd0 : ins[15:11];
        if (op == 6'h03) return 5'd31;
        if (op inside {6'h02, 6'h04, 6'h05, 6'h2B}) return 5'd0;
        return ins[20:16];
    endfunction

    function automatic bit is_ctrl(input logic [31:0] ins);
        return (ins[31:26] inside {6'h02, 6'h03, 6'h04, 6'h05}) ||
               (ins[31:26] == 6'h00 && ins[5:0] == 6'h08);
    endfunction

    function automatic bit hazard(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] d = dest_of(a);
        return is_ctrl(a) || (d != 5'd0 && (d == b[25:21] || d == b[20:16]));
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   n = mq.size();
        bit   hz;
        e       = '0;
        hz      = (n >= 2) && hazard(mq[0].instr, mq[1].instr);
        e.count = CW'(n);
        e.ready = (int'(DEPTH) - n) >= 2;
        e.split = hz;
        if (n >= 1) begin
            e.v0 = 1'b1;
            e.i0 = mq[0].instr;
            e.p0 = mq[0].pc;
        end
        if (n >= 2 && !hz) begin
            e.v1 = 1'b1;
            e.i1 = mq[1].instr;
            e.p1 = mq[1].pc;
        end
        return e;
    endfunction

    function automatic logic [31:0] indep(input int k);
        return rtype(5'd1, 5'd2, 5'(16 + (k % 8)), 6'h20);
    endfunction

    function automatic logic [31:0] rnd_instr();
        int unsigned sel = $urandom_range(0, 10);
        logic [4:0]  rs = 5'($urandom_range(0, 7));
        logic [4:0]  rt = 5'($urandom_range(0, 7));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom);
        case (sel)
            0, 1, 2: return rtype(rs, rt, rd, ($urandom_range(0, 1) != 0) ? 6'h20 : 6'h25);
            3:       return rtype(rs, 5'd0, 5'd0, 6'h08);
            4:       return itype(6'h02, rs, rt, imm);
            5:       return itype(6'h03, rs, rt, imm);
            6:       return itype(6'h04, rs, rt, imm);
            7:       return itype(6'h05, rs, rt, imm);
            8:       return itype(6'h2B, rs, rt, imm);
            9:       return itype(6'h23, rs, rt, imm);
            default: return itype(6'h08, rs, rt, imm);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
        end
    endtask

    // Called at posedge+1; pushes the expectation for the current state, then
    // drives this cycle's inputs and advances the model to the next state.
    task automatic cycle(input bit f, input bit a, input bit b, input bit r,
                         input logic [31:0] ia, input logic [31:0] ib);
        exp_t        e;
        int          nd;
        logic [31:0] pa;
        logic [31:0] pb;
        e = model_out();
        eq.push_back(e);
        pa = next_pc;
        pb = next_pc + 32'd4;
        if (a) next_pc = next_pc + (b ? 32'd8 : 32'd4);
        iq_i_flush       = f;
        iq_i_valid_0     = a;
        iq_i_valid_1     = a && b;
        iq_i_issue_ready = r;
        iq_i_instr_0     = ia;
        iq_i_instr_1     = ib;
        iq_i_pc_0        = pa;
        iq_i_pc_1        = pb;
        if (f) begin
            mq.delete();
        end else begin
            if (r) begin
                nd = e.v1 ? 2 : (e.v0 ? 1 : 0);
                repeat (nd) void'(mq.pop_front());
            end
            if (e.ready && a) begin
                mq.push_back('{instr: ia, pc: pa});
                if (b) mq.push_back('{instr: ib, pc: pb});
            end
        end
        @(posedge iq_clk);
        #1;
    endtask

    task automatic idle(input bit r);
        cycle(1'b0, 1'b0, 1'b0, r, '0, '0);
    endtask

    task automatic pair(input bit r);
        cycle(1'b0, 1'b1, 1'b1, r, indep(kk), indep(kk + 1));
        kk += 2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge iq_clk);
            #3;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("valid_0", 32'(iq_o_issue_valid_0), 32'(e.v0));
                chk("valid_1", 32'(iq_o_issue_valid_1), 32'(e.v1));
                chk("split",   32'(iq_o_split),         32'(e.split));
                chk("ready",   32'(iq_o_ready),         32'(e.ready));
                chk("count",   32'(iq_o_count),         32'(e.count));
                chk("instr_0", iq_o_instr_0, e.i0);
                chk("pc_0",    iq_o_pc_0,    e.p0);
                chk("instr_1", iq_o_instr_1, e.i1);
                chk("pc_1",    iq_o_pc_1,    e.p1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [31:0] add3, sub5, or7, beq12, add8;
        add3  = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        sub5  = rtype(5'd4, 5'd6, 5'd5, 6'h22);
        or7   = rtype(5'd3, 5'd4, 5'd7, 6'h25);
        beq12 = itype(6'h04, 5'd1, 5'd2, 16'h0010);
        add8  = rtype(5'd9, 5'd10, 5'd8, 6'h20);

        repeat (2) @(posedge iq_clk);
        #2 iq_rst = 1'b1;
        @(posedge iq_clk);
        #1;

        // Independent pair, then a dependent pair, then a branch pair
        idle(1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, add3, sub5);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, add3, or7);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, beq12, add8);
        idle(1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, add3, sub5);
        chk("flush_count", 32'(iq_o_count), 32'd0);
        chk("flush_valid", 32'(iq_o_issue_valid_0), 32'd0);
        idle(1'b0);

        // Fill to full with pairs; fifth pair is dropped
        repeat (5) pair(1'b0);
        chk("full_count", 32'(iq_o_count), 32'd8);
        chk("full_ready", 32'(iq_o_ready), 32'd0);
        repeat (5) idle(1'b1);
        chk("drain_count", 32'(iq_o_count), 32'd0);

        // Odd fill: ready drops at DEPTH-1
        cycle(1'b0, 1'b1, 1'b0, 1'b0, indep(kk), '0);
        kk++;
        repeat (3) pair(1'b0);
        chk("dm1_count", 32'(iq_o_count), 32'd7);
        chk("dm1_ready", 32'(iq_o_ready), 32'd0);
        pair(1'b0);
        chk("dm1_drop", 32'(iq_o_count), 32'd7);
        repeat (5) idle(1'b1);

        // Streaming 2-in/2-out across the wrap
        repeat (10) pair(1'b1);
        repeat (2) idle(1'b1);

        // Random traffic with frequent hazards
        repeat (400) begin
            bit f, a, b, r;
            a = $urandom_range(0, 3) != 0;
            b = a && ($urandom_range(0, 1) != 0);
            r = $urandom_range(0, 3) != 0;
            f = $urandom_range(0, 29) == 0;
            cycle(f, a, b, r, rnd_instr(), rnd_instr());
        end

        // Reset asserted between edges with entries in flight
        pair(1'b0);
        pair(1'b0);
        #3 iq_rst = 1'b0;
        #1;
        chk("rst_valid_0", 32'(iq_o_issue_valid_0), 32'd0);
        chk("rst_valid_1", 32'(iq_o_issue_valid_1), 32'd0);
        chk("rst_split",   32'(iq_o_split), 32'd0);
        chk("rst_ready",   32'(iq_o_ready), 32'd1);
        chk("rst_count",   32'(iq_o_count), 32'd0);
        chk("rst_instr_0", iq_o_instr_0, 32'd0);
        chk("rst_pc_0",    iq_o_pc_0, 32'd0);
        mq.delete();
        iq_i_valid_0 = 1'b0;
        iq_i_valid_1 = 1'b0;
        @(posedge iq_clk);
        #2 iq_rst = 1'b1;
        @(posedge iq_clk);
        #1;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, add3, sub5);
        idle(1'b1);
        idle(1'b1);

        chk("scoreboard_empty", 32'(eq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
